// File: rtl/ref_sample_gather.sv
// ref_sample_gather: fetches the 4x4 intra block neighbour samples, pads unavailable segments
// and presents the 8 top and 8 left references on a single out_valid pulse.
module ref_sample_gather #(
  parameter int BIT_DEPTH   = 8,
  parameter int DEFAULT_VAL = 1 << (BIT_DEPTH - 1)
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [3:0]           avail_i,
  output logic                 busy_o,
  output logic                 rd_en_o,
  output logic [1:0]           rd_seg_o,
  output logic [1:0]           rd_idx_o,
  input  logic [BIT_DEPTH-1:0] rd_data_i,
  output logic                 out_valid_o,
  output logic [BIT_DEPTH-1:0] ref_top_o  [8],
  output logic [BIT_DEPTH-1:0] ref_left_o [8]
);
  localparam logic [BIT_DEPTH-1:0] DEF = BIT_DEPTH'(DEFAULT_VAL);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_FILL, S_DONE} state_e;
  state_e               state_q, state_d;
  logic [3:0]           k_q, k_d;
  logic [3:0]           avail_q, avail_d;
  logic                 rd_pend_q;
  logic [3:0]           rd_k_q;
  logic [BIT_DEPTH-1:0] buf_q [16];
  logic [BIT_DEPTH-1:0] buf_d [16];
  logic [BIT_DEPTH-1:0] ref_top_q  [8];
  logic [BIT_DEPTH-1:0] ref_left_q [8];
  logic [3:0]           later;
  logic [3:0]           f;
  function automatic logic [1:0] first_seg(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  // Slots are in scan order: k=0 is LEFT7 (below-left idx 3), k=8 is TOP0.
  assign later       = avail_q & (4'b1110 << k_q[3:2]);
  assign f           = {first_seg(avail_q), 2'b00};
  assign busy_o      = state_q != S_IDLE;
  assign rd_en_o     = state_q == S_FETCH;
  assign rd_seg_o    = rd_en_o ? k_q[3:2] : 2'd0;
  assign rd_idx_o    = rd_en_o ? (k_q[3] ? k_q[1:0] : ~k_q[1:0]) : 2'd0;
  assign out_valid_o = state_q == S_DONE;
  assign ref_top_o   = ref_top_q;
  assign ref_left_o  = ref_left_q;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    avail_d = avail_q;
    buf_d   = buf_q;
    if (rd_pend_q) buf_d[rd_k_q] = rd_data_i;
    case (state_q)
      S_IDLE: if (start_i) begin
        avail_d = avail_i;
        k_d     = (avail_i == 4'd0) ? 4'd0 : {first_seg(avail_i), 2'b00};
        state_d = (avail_i == 4'd0) ? S_FILL : S_FETCH;
      end
      S_FETCH: begin
        k_d     = (k_q[1:0] != 2'd3) ? k_q + 4'd1 : {first_seg(later), 2'b00};
        state_d = (k_q[1:0] == 2'd3 && later == 4'd0) ? S_WAIT : S_FETCH;
      end
      S_WAIT: begin
        k_d     = 4'd0;
        state_d = S_FILL;
      end
      S_FILL: begin
        // Earlier slots are final by now, so padding chains forward one slot per cycle.
        buf_d[k_q] = (avail_q == 4'd0) ? DEF :
                     avail_q[k_q[3:2]] ? buf_q[k_q] :
                     (k_q < f) ? buf_q[f] : buf_q[4'(k_q - 4'd1)];
        k_d     = k_q + 4'd1;
        state_d = (k_q == 4'd15) ? S_DONE : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 4'd0;
      avail_q    <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_k_q     <= 4'd0;
      buf_q      <= '{default: '0};
      ref_top_q  <= '{default: '0};
      ref_left_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      avail_q   <= avail_d;
      rd_pend_q <= state_q == S_FETCH;
      rd_k_q    <= k_q;
      buf_q     <= buf_d;
      if (state_d == S_DONE) begin
        for (int i = 0; i < 8; i++) begin
          ref_left_q[i] <= buf_d[7-i];
          ref_top_q[i]  <= buf_d[8+i];
        end
      end
    end
  end
endmodule

// File: tb/tb_ref_sample_gather.sv
// tb_ref_sample_gather: directed scoreboard bench for ref_sample_gather.
module tb_ref_sample_gather;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] avail = 4'd0;
  logic       busy, rd_en, out_valid;
  logic [1:0] rd_seg, rd_idx;
  logic [7:0] rd_data = 8'd0;
  logic [7:0] ref_top [8];
  logic [7:0] ref_left [8];
  logic [7:0] mem [4][4];
  logic [7:0] exp_left [8];
  logic [7:0] exp_top [8];
  logic [7:0] sb [$];
  int tests = 0, fails = 0, rd_cnt = 0, ov_cnt = 0;

  ref_sample_gather dut (
    .clk1(clk), .rst_n(rst_n), .start_i(start), .avail_i(avail), .busy_o(busy),
    .rd_en_o(rd_en), .rd_seg_o(rd_seg), .rd_idx_o(rd_idx), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .ref_top_o(ref_top), .ref_left_o(ref_left)
  );

  always #5 clk = ~clk;

  // Reconstruction buffer: data one cycle after the read strobe.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_seg][rd_idx] : 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) rd_cnt++;
      if (out_valid) begin
        ov_cnt++;
        if (sb.size() < 16) check("sb_underflow", sb.size(), 16);
        else begin
          for (int i = 0; i < 8; i++) check($sformatf("ref_left%0d", i), ref_left[i], sb.pop_front());
          for (int i = 0; i < 8; i++) check($sformatf("ref_top%0d", i), ref_top[i], sb.pop_front());
        end
      end
    end
  end

  task automatic push_exp();
    for (int i = 0; i < 8; i++) sb.push_back(exp_left[i]);
    for (int i = 0; i < 8; i++) sb.push_back(exp_top[i]);
  endtask

  task automatic setup_full();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++) mem[s][i] = 8'(10 * (4 * s + i));
    for (int y = 0; y < 4; y++) begin
      exp_left[y]   = 8'(40 + 10 * y);
      exp_left[y+4] = 8'(10 * y);
      exp_top[y]    = 8'(80 + 10 * y);
      exp_top[y+4]  = 8'(120 + 10 * y);
    end
  endtask

  task automatic run_job(input logic [3:0] av, input int lat, input int nrd, input string name);
    int rd0, ov0, cyc;
    rd0 = rd_cnt;
    ov0 = ov_cnt;
    push_exp();
    avail = av;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, cyc, lat);
    check({name, "_reads"}, rd_cnt - rd0, nrd);
    check({name, "_valid_pulses"}, ov_cnt - ov0, 1);
  endtask

  initial begin
    int ov0, cyc, rises;
    logic prev;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++) mem[s][i] = 8'd99;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_seg", rd_seg, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_out_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rst_top%0d", i), ref_top[i], 0);
      check($sformatf("rst_left%0d", i), ref_left[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    setup_full();
    run_job(4'hF, 34, 16, "all");

    for (int i = 0; i < 8; i++) begin
      exp_left[i] = 8'd128;
      exp_top[i]  = 8'd128;
    end
    run_job(4'h0, 17, 0, "none");
    check("none_hold_top3", ref_top[3], 128);

    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++) mem[s][i] = 8'd99;
    for (int i = 0; i < 4; i++) mem[2][i] = 8'(5 + i);
    for (int i = 0; i < 8; i++) exp_left[i] = 8'd5;
    for (int i = 0; i < 4; i++) begin
      exp_top[i]   = 8'(5 + i);
      exp_top[i+4] = 8'd8;
    end
    run_job(4'b0100, 22, 4, "top_only");

    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++) mem[s][i] = 8'd99;
    for (int j = 0; j < 4; j++) begin
      mem[0][3-j] = 8'(20 + j);
      mem[1][3-j] = 8'(24 + j);
    end
    for (int k = 0; k < 8; k++) begin
      exp_left[7-k] = 8'(20 + k);
      exp_top[k]    = 8'd27;
    end
    run_job(4'b0011, 26, 8, "left_only");

    setup_full();
    push_exp();
    push_exp();
    ov0 = ov_cnt;
    rises = 0;
    prev = 1'b0;
    avail = 4'hF;
    @(negedge clk) start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
    end
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("held_start_accepts", rises, 2);
    check("held_start_valids", ov_cnt - ov0, 2);

    push_exp();
    ov0 = ov_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_top0", ref_top[0], 0);
    check("abort_left7", ref_left[7], 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_valid", ov_cnt - ov0, 0);
    run_job(4'hF, 34, 16, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
